// File: rtl/display_pkg.sv
// Shared source codes, FSM encoding and source-rotation helper for the display scheduler.
package display_pkg;

    localparam int unsigned NUM_SRC = 3;

    localparam logic [1:0] SRC_COUNT = 2'd0;
    localparam logic [1:0] SRC_HEAD  = 2'd1;
    localparam logic [1:0] SRC_LAST  = 2'd2;

    typedef enum logic {
        ST_SHOW,
        ST_ALERT
    } state_e;

    // Rotate count -> head -> last -> count; code 3 never appears.
    function automatic logic [1:0] next_src(input logic [1:0] sel);
        return (sel == SRC_LAST) ? SRC_COUNT : sel + 2'd1;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Free-running modulo-PERIOD counter with a one-cycle terminal pulse.
// tick_o is high while the counter sits at PERIOD-1 and is enabled; the counter wraps on that edge.
module tick_timer #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntMax);

    // Next count: clear wins over counting; wrap to zero at terminal.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_sched.sv
// Time-shares a two-digit readout between three status sources with dwell rotation,
// hold/next controls and a blinking occupancy alert that pre-empts rotation.
module display_sched #(
    parameter int unsigned DWELL_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES  = 12_500_000,
    parameter int unsigned ALERT_TOGGLES = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] src_count_i,
    input  logic [5:0] src_head_i,
    input  logic [5:0] src_last_i,
    input  logic       hold_i,
    input  logic       next_i,
    input  logic       alert_i,
    output logic [5:0] disp_data_o,
    output logic       disp_blank_o,
    output logic [1:0] src_sel_o
);

    import display_pkg::*;

    localparam int unsigned TogW = $clog2(ALERT_TOGGLES + 1);
    localparam logic [TogW-1:0] TogLast = TogW'(ALERT_TOGGLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      saved_q, saved_d;
    logic [TogW-1:0] tog_q, tog_d;
    logic            blank_q, blank_d;
    logic [5:0]      data_q, data_d;

    logic dwell_tick, blink_tick;
    logic dwell_clr, dwell_en;
    logic blink_clr, blink_en;

    // Dwell only runs in SHOW; it is held at zero through an alert so SHOW resumes fresh.
    assign dwell_en  = (state_q == ST_SHOW) && !hold_i;
    assign dwell_clr = alert_i || next_i || (state_q == ST_ALERT);
    assign blink_en  = (state_q == ST_ALERT);
    assign blink_clr = alert_i || (state_q == ST_SHOW);

    tick_timer #(
        .PERIOD (DWELL_CYCLES)
    ) u_dwell (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (dwell_clr),
        .en_i   (dwell_en),
        .tick_o (dwell_tick)
    );

    tick_timer #(
        .PERIOD (BLINK_CYCLES)
    ) u_blink (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (blink_clr),
        .en_i   (blink_en),
        .tick_o (blink_tick)
    );

    // Next-state logic: alert pre-empts everything, then per-state rotation or blinking.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        saved_d = saved_q;
        tog_d   = tog_q;
        blank_d = blank_q;
        if (alert_i) begin
            state_d = ST_ALERT;
            sel_d   = SRC_COUNT;
            blank_d = 1'b0;
            tog_d   = '0;
            // A restart keeps the selection that was showing before the first alert.
            if (state_q == ST_SHOW) begin
                saved_d = sel_q;
            end
        end else begin
            unique case (state_q)
                ST_SHOW: begin
                    blank_d = 1'b0;
                    if (next_i || dwell_tick) begin
                        sel_d = next_src(sel_q);
                    end
                end
                ST_ALERT: begin
                    if (blink_tick) begin
                        blank_d = ~blank_q;
                        if (tog_q == TogLast) begin
                            // Even toggle count: blank lands back at 0 on exit.
                            state_d = ST_SHOW;
                            sel_d   = saved_q;
                            tog_d   = '0;
                        end else begin
                            tog_d = tog_q + TogW'(1);
                        end
                    end
                end
                default: state_d = ST_SHOW;
            endcase
        end
    end

    // Registered source mux, driven by the selection currently in effect.
    always_comb begin
        data_d = src_count_i;
        unique case (sel_q)
            SRC_COUNT: data_d = src_count_i;
            SRC_HEAD:  data_d = src_head_i;
            SRC_LAST:  data_d = src_last_i;
            default:   data_d = src_count_i;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_SHOW;
            sel_q   <= SRC_COUNT;
            saved_q <= SRC_COUNT;
            tog_q   <= '0;
            blank_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            saved_q <= saved_d;
            tog_q   <= tog_d;
            blank_q <= blank_d;
            data_q  <= data_d;
        end
    end

    assign disp_data_o  = data_q;
    assign disp_blank_o = blank_q;
    assign src_sel_o    = sel_q;

endmodule

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with small dwell/blink parameters.
module tb_display_sched;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLINK  = 2;
    localparam int unsigned TOGGLE = 4;

    logic       clk;
    logic       rst_n;
    logic [5:0] src_count, src_head, src_last;
    logic       hold, next, alert;
    logic [5:0] disp_data;
    logic       disp_blank;
    logic [1:0] src_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       hold;
        logic       next;
        logic       alert;
        logic [1:0] sel;
        logic [5:0] data;
        logic       blank;
    } vec_t;

    vec_t vecs[$];

    display_sched #(
        .DWELL_CYCLES  (DWELL),
        .BLINK_CYCLES  (BLINK),
        .ALERT_TOGGLES (TOGGLE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src_count_i  (src_count),
        .src_head_i   (src_head),
        .src_last_i   (src_last),
        .hold_i       (hold),
        .next_i       (next),
        .alert_i      (alert),
        .disp_data_o  (disp_data),
        .disp_blank_o (disp_blank),
        .src_sel_o    (src_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic h, input logic n, input logic a,
                       input logic [1:0] s, input logic [5:0] d, input logic b);
        vec_t v;
        v.rst_n = r; v.hold = h; v.next = n; v.alert = a;
        v.sel = s; v.data = d; v.blank = b;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, clock once, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic h, input logic n, input logic a,
                        input logic [1:0] s, input logic [5:0] d, input logic b,
                        input string name);
        @(negedge clk);
        rst_n = r; hold = h; next = n; alert = a;
        @(posedge clk);
        #1;
        checks++;
        if (src_sel !== s || disp_data !== d || disp_blank !== b) begin
            errors++;
            $display("FAIL %s: got sel=%0d data=%0d blank=%0b, expected sel=%0d data=%0d blank=%0b",
                     name, src_sel, disp_data, disp_blank, s, d, b);
        end
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; next = 1'b0; alert = 1'b0;
        src_count = 6'd37; src_head = 6'd5; src_last = 6'd63;

        // Reset, full rotation, next on dwell terminal, alert from source 2.
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 37, 0);
        add(1, 0, 0, 0, 1, 37, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 5, 0);
        add(1, 0, 0, 0, 2, 5, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 2, 63, 0);
        add(1, 0, 0, 0, 0, 63, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 37, 0);
        add(1, 0, 1, 0, 1, 37, 0);          // next coincides with dwell terminal
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 5, 0);
        add(1, 0, 0, 0, 2, 5, 0);
        add(1, 0, 0, 0, 2, 63, 0);
        add(1, 0, 0, 1, 0, 63, 0);          // alert while showing source 2
        add(1, 0, 0, 0, 0, 37, 0);
        add(1, 0, 0, 0, 0, 37, 1);
        add(1, 0, 0, 0, 0, 37, 1);
        add(1, 0, 0, 0, 0, 37, 0);
        add(1, 0, 0, 0, 0, 37, 0);
        add(1, 0, 0, 0, 0, 37, 1);
        add(1, 0, 0, 0, 0, 37, 1);
        add(1, 0, 0, 0, 2, 37, 0);          // back to SHOW on saved source
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 2, 63, 0);
        add(1, 0, 0, 0, 0, 63, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].hold, vecs[i].next, vecs[i].alert,
                 vecs[i].sel, vecs[i].data, vecs[i].blank, $sformatf("vec%0d", i));
        end

        // Hold mid-dwell at count 2, then release: advance two cycles later.
        step(1, 0, 0, 0, 0, 37, 0, "dwell1");
        step(1, 0, 0, 0, 0, 37, 0, "dwell2");
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 37, 0, "hold_frozen");
        step(1, 0, 0, 0, 0, 37, 0, "hold_release1");
        step(1, 0, 0, 0, 1, 37, 0, "hold_release2");
        // next during hold advances at once and clears the dwell count.
        step(1, 1, 1, 0, 2, 5, 0, "next_in_hold");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 2, 63, 0, "hold_after_next");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 2, 63, 0, "full_dwell");
        step(1, 0, 0, 0, 0, 63, 0, "full_dwell_end");

        // Alert restart three cycles in; next/hold ignored; return to source 1.
        step(1, 0, 1, 0, 1, 37, 0, "pre_alert_next");
        step(1, 0, 0, 1, 0, 5, 0, "alert1");
        step(1, 0, 1, 0, 0, 37, 0, "alert1_next_ignored");
        step(1, 0, 0, 0, 0, 37, 1, "alert1_blank");
        step(1, 0, 0, 1, 0, 37, 0, "alert_restart");
        for (int k = 1; k < 8; k++) begin
            step(1, (k == 2 || k == 3), (k == 1 || k == 5), 0, 0, 37, 1'((k >> 1) & 1),
                 $sformatf("restart_blink%0d", k));
        end
        step(1, 0, 0, 0, 1, 37, 0, "restart_return");

        // Reset while blanked in ALERT, then a full dwell with a live source change.
        step(1, 0, 0, 1, 0, 5, 0, "alert2");
        step(1, 0, 0, 0, 0, 37, 0, "alert2_a");
        step(1, 0, 0, 0, 0, 37, 1, "alert2_blank");
        step(0, 0, 0, 0, 0, 0, 0, "reset_mid_alert");
        step(1, 0, 0, 0, 0, 37, 0, "post_reset1");
        src_count = 6'd12;
        step(1, 0, 0, 0, 0, 12, 0, "live_source");
        step(1, 0, 0, 0, 0, 12, 0, "post_reset3");
        step(1, 0, 0, 0, 1, 12, 0, "post_reset_advance");
        step(1, 0, 0, 0, 1, 5, 0, "post_reset_head");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_sched.md
# display_sched

Time-shares the queue's two-digit seven-segment readout between three 6-bit status sources: queue occupancy, head-of-queue data and last-written data. It auto-rotates on a dwell timer, accepts hold/advance controls from debounced buttons, and pre-empts rotation with a blinking occupancy alert on overflow/underflow events. Its `disp_data` output feeds the decimal seven-segment encoder directly. `disp_blank` is applied at top level to force both digit outputs to 8'hFF.

## Interface
- DWELL_CYCLES, 50_000_000, clock cycles each source is shown during rotation (≥2)
- BLINK_CYCLES, 12_500_000, clock cycles per blink half-period in alert (≥1)
- ALERT_TOGGLES, 6, number of blank toggles per alert; must be even, ≥2
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- src_count  in  6  queue occupancy
- src_head  in  6  data at queue head
- src_last  in  6  last value written to queue
- hold  in  1  level; freezes rotation timer while high
- next  in  1  single-cycle pulse; advance to next source immediately
- alert  in  1  single-cycle pulse; start (or restart) occupancy alert
- disp_data  out  6  value to display
- disp_blank  out  1  1 = display must be blanked
- src_sel  out  2  source currently shown: 0 count, 1 head, 2 last (3 never driven)

## Operation
- States: SHOW, ALERT.
- Reset (rst_n low at an edge) sets:
  - state=SHOW, src_sel=0, disp_data=0, disp_blank=0
  - dwell counter=0, blink counter=0, toggle counter=0, saved_sel=0
- SHOW:
  - Dwell counter increments each cycle while hold=0; it holds its value (not cleared) while hold=1.
  - Dwell terminal (counter = DWELL_CYCLES-1, hold=0): src_sel advances 0→1→2→0, counter clears.
  - next=1: src_sel advances and the dwell counter clears, regardless of hold.
  - next coinciding with dwell terminal: advance exactly once.
  - disp_blank=0 throughout SHOW.
- alert=1 (any state) takes priority over next and the dwell timer. The following cycle:
  - state=ALERT, src_sel=0, disp_blank=0
  - blink and toggle counters clear
  - saved_sel captures the pre-alert src_sel; this happens only when entering from SHOW, so a restart keeps the original value.
- ALERT:
  - Blink counter counts 0..BLINK_CYCLES-1. At terminal: disp_blank inverts, toggle counter increments.
  - When the ALERT_TOGGLES-th toggle occurs: state=SHOW, src_sel=saved_sel, dwell counter=0. disp_blank is 0 at this point because the toggle count is even.
  - next and hold are ignored in ALERT.
  - A new alert pulse restarts the alert as on entry.
- disp_data is the registered mux of src_count/src_head/src_last by the src_sel value in effect that cycle. Sources are sampled live every cycle (not frozen).
- Width rules:
  - Counters are sized by $clog2 of their parameter.
  - Toggle counter is $clog2(ALERT_TOGGLES+1) bits.
  - No truncation of the 6-bit data.

## Timing
- All outputs are registered; no combinational input→output path.
- Source value change → disp_data updated 1 cycle later.
- next pulse at edge N → src_sel new value after edge N, disp_data of new source after edge N+1.
- Dwell: with hold=0, each source is shown for exactly DWELL_CYCLES cycles.
- alert at edge N:
  - src_sel=0 after edge N.
  - First blank=1 after edge N+BLINK_CYCLES.
  - SHOW resumes after edge N+ALERT_TOGGLES·BLINK_CYCLES.
- rst_n low mid-alert or mid-dwell: reset values after that edge; no residual blanking.

## Structure
- Shared package `display_pkg`:
  - source codes SRC_COUNT=2'd0, SRC_HEAD=2'd1, SRC_LAST=2'd2
  - state encoding ST_SHOW, ST_ALERT
  - NUM_SRC=3
- One sub-module, `tick_timer` (parameter PERIOD; ports clk, rst_n, clr, en, tick).
  - tick is a one-cycle terminal pulse; counter wraps to 0 on tick.
  - Instantiated twice: dwell and blink.
- Top: state register, saved_sel, toggle counter, source mux and output registers.

## Test plan
Scenarios 1–5 use DWELL_CYCLES=4, BLINK_CYCLES=2, ALERT_TOGGLES=4, with src_count=37, src_head=5, src_last=63.
1. Release reset, hold=0 → src_sel 0,1,2,0 each for 4 cycles; disp_data 37,5,63 lagging src_sel by 1 cycle; disp_blank=0.
2. hold=1 for 10 cycles mid-dwell (counter=2), then release → src_sel unchanged during hold; advances 2 cycles after release. A next pulse during hold advances immediately.
3. next pulse on the dwell-terminal cycle → src_sel advances by exactly one (0→1, not 2).
4. At src_sel=2, alert pulse → src_sel=0, disp_data=37; disp_blank pattern 0,0,1,1,0,0,1,1 → then 0. Return to SHOW with src_sel=2 after 8 cycles.
5. Second alert 3 cycles into an alert → blink sequence restarts from 0; return still to src_sel=2. next pulses during alert have no effect.
6. rst_n low for one edge while disp_blank=1 in ALERT → after that edge: state SHOW, src_sel=0, disp_blank=0, disp_data=0; rotation restarts with full dwell.
